// File: rtl/fft_bin_scanner.sv
// Sweeps dit_fft_8 bins 0..NBINS-1, captures each after a settle delay, streams magnitudes and reports the peak bin.
// Define FFT_SCAN_SQMAG_EN for re^2+im^2 magnitude; default build uses |re|+|im|.
module fft_bin_scanner #(
    parameter int SETTLE = 2,
    parameter int NBINS  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [2:0]         sel,
    input  logic signed [8:0]  y_real,
    input  logic signed [8:0]  y_img,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_bin,
    output logic signed [8:0]  out_re,
    output logic signed [8:0]  out_im,
    output logic [17:0]        out_mag,
    output logic               busy,
    output logic               done,
    output logic [2:0]         peak_bin,
    output logic [17:0]        peak_mag
);

    typedef enum logic [1:0] {IDLE, SETTLE_WAIT, OUTPUT, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [2:0]         bin_q, bin_d;
    logic signed [8:0]  re_q, re_d;
    logic signed [8:0]  im_q, im_d;
    logic [17:0]        mag_q, mag_d;
    logic [2:0]         run_bin_q, run_bin_d;
    logic [17:0]        run_mag_q, run_mag_d;
    logic [2:0]         peak_bin_q, peak_bin_d;
    logic [17:0]        peak_mag_q, peak_mag_d;

    logic               settled;
    logic               accept;
    logic               last_bin;
    logic               better;

    // Absolute values are formed at 10 bits so that |-256| stays exact.
    function automatic logic [17:0] mag_f(input logic signed [8:0] re, input logic signed [8:0] im);
`ifdef FFT_SCAN_SQMAG_EN
        logic signed [17:0] pr;
        logic signed [17:0] pi;
        pr = re * re;
        pi = im * im;
        return $unsigned(pr) + $unsigned(pi);
`else
        logic signed [9:0] ar;
        logic signed [9:0] ai;
        ar = (re < 0) ? -10'(re) : 10'(re);
        ai = (im < 0) ? -10'(im) : 10'(im);
        return 18'($unsigned(ar)) + 18'($unsigned(ai));
`endif
    endfunction

    assign settled  = (cnt_q == 4'(SETTLE - 1));
    assign accept   = valid_q && out_ready;
    assign last_bin = (sel_q == 3'(NBINS - 1));
    assign better   = (mag_q > run_mag_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            bin_q      <= '0;
            re_q       <= '0;
            im_q       <= '0;
            mag_q      <= '0;
            run_bin_q  <= '0;
            run_mag_q  <= '0;
            peak_bin_q <= '0;
            peak_mag_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            bin_q      <= bin_d;
            re_q       <= re_d;
            im_q       <= im_d;
            mag_q      <= mag_d;
            run_bin_q  <= run_bin_d;
            run_mag_q  <= run_mag_d;
            peak_bin_q <= peak_bin_d;
            peak_mag_q <= peak_mag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (start) state_d = SETTLE_WAIT;
            SETTLE_WAIT: if (settled) state_d = OUTPUT;
            OUTPUT:      if (accept) state_d = last_bin ? DONE : SETTLE_WAIT;
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        bin_d      = bin_q;
        re_d       = re_q;
        im_d       = im_q;
        mag_d      = mag_q;
        run_bin_d  = run_bin_q;
        run_mag_d  = run_mag_q;
        peak_bin_d = peak_bin_q;
        peak_mag_d = peak_mag_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d     = '0;
                    cnt_d     = '0;
                    run_bin_d = '0;
                    run_mag_d = '0;
                end
            end
            SETTLE_WAIT: begin
                if (settled) begin
                    re_d    = y_real;
                    im_d    = y_img;
                    mag_d   = mag_f(y_real, y_img);
                    bin_d   = sel_q;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            OUTPUT: begin
                if (accept) begin
                    valid_d = 1'b0;
                    // Strictly greater keeps the lowest bin on ties.
                    if (better) begin
                        run_bin_d = bin_q;
                        run_mag_d = mag_q;
                    end
                    if (last_bin) begin
                        peak_bin_d = better ? bin_q : run_bin_q;
                        peak_mag_d = better ? mag_q : run_mag_q;
                    end else begin
                        sel_d = sel_q + 3'd1;
                        cnt_d = '0;
                    end
                end
            end
            DONE:    sel_d = '0;
            default: sel_d = '0;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign out_bin   = bin_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign out_mag   = mag_q;
    assign peak_bin  = peak_bin_q;
    assign peak_mag  = peak_mag_q;

endmodule

// File: tb/tb_fft_bin_scanner.sv
// Directed bench for fft_bin_scanner with a table-driven behavioural FFT stub.
module tb_fft_bin_scanner;

    logic        clk = 1'b0;
    logic        rst_n, start, out_ready;
    logic [2:0]  sel, out_bin, peak_bin;
    logic [8:0]  y_real, y_img, out_re, out_im;
    logic        out_valid, busy, done;
    logic [17:0] out_mag, peak_mag;

    always #5 clk = ~clk;

    fft_bin_scanner #(.SETTLE(2), .NBINS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
        .y_real(y_real), .y_img(y_img),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_re(out_re), .out_im(out_im), .out_mag(out_mag),
        .busy(busy), .done(done), .peak_bin(peak_bin), .peak_mag(peak_mag)
    );

    typedef struct {
        logic [7:0][8:0]  re;
        logic [7:0][8:0]  im;
        logic [7:0][17:0] mag_l1;
        logic [7:0][17:0] mag_sq;
        logic [2:0]       pk_bin;
        logic [17:0]      pk_l1;
        logic [17:0]      pk_sq;
        bit               toggle;
        bit               mid_start;
        bit               start_at_done;
    } frame_t;

    frame_t tbl[4];
    int     cur = 0;
    int     n_cmp = 0;
    int     n_fail = 0;

    always_comb begin
        y_real = tbl[cur].re[sel];
        y_img  = tbl[cur].im[sel];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [17:0] exp_mag(input int f, input int b);
`ifdef FFT_SCAN_SQMAG_EN
        return tbl[f].mag_sq[b];
`else
        return tbl[f].mag_l1[b];
`endif
    endfunction

    function automatic logic [17:0] exp_pk(input int f);
`ifdef FFT_SCAN_SQMAG_EN
        return tbl[f].pk_sq;
`else
        return tbl[f].pk_l1;
`endif
    endfunction

    task automatic run_frame(input int f);
        int          words = 0;
        int          first_v = -1;
        bit          finished = 1'b0;
        bit          stalled_prev = 1'b0;
        logic [63:0] saved = '0;
        cur = f;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
            @(negedge clk);
            start = (tbl[f].mid_start && cyc == 10);
            out_ready = tbl[f].toggle ? (((cyc / 3) % 2) == 0) : 1'b1;
            if (stalled_prev)
                check("stall_hold", {22'd0, sel, out_bin, out_re, out_im, out_mag}, saved);
            if (out_valid && first_v < 0) begin
                first_v = cyc;
                check("first_valid_lat", cyc, 3);
            end
            if (out_valid && out_ready) begin
                check("word_bin", out_bin, words);
                check("word_re", out_re, tbl[f].re[words]);
                check("word_im", out_im, tbl[f].im[words]);
                check("word_mag", out_mag, exp_mag(f, words));
                check("sel_eq_bin", sel, out_bin);
                words++;
            end
            stalled_prev = out_valid && !out_ready;
            saved = {22'd0, sel, out_bin, out_re, out_im, out_mag};
            if (done) begin
                finished = 1'b1;
                if (!tbl[f].toggle) check("done_cycle", cyc, 25);
                check("word_count", words, 8);
                check("peak_bin", peak_bin, tbl[f].pk_bin);
                check("peak_mag", peak_mag, exp_pk(f));
                if (tbl[f].start_at_done) start = 1'b1;
            end
        end
        if (!finished) check("done_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        @(negedge clk);
        check("still_idle", busy, 0);
        check("peak_hold", peak_mag, exp_pk(f));
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            tbl[0].re[k]     = 9'(10 * k);
            tbl[0].im[k]     = 9'(-k);
            tbl[0].mag_l1[k] = 18'(11 * k);
            tbl[0].mag_sq[k] = 18'(101 * k * k);
            tbl[1].re[k] = '0; tbl[1].im[k] = '0; tbl[1].mag_l1[k] = '0; tbl[1].mag_sq[k] = '0;
            tbl[2].re[k] = '0; tbl[2].im[k] = '0; tbl[2].mag_l1[k] = '0; tbl[2].mag_sq[k] = '0;
        end
        tbl[0].pk_bin = 3'd7; tbl[0].pk_l1 = 18'd77; tbl[0].pk_sq = 18'd4949;
        tbl[0].toggle = 1'b0; tbl[0].mid_start = 1'b0; tbl[0].start_at_done = 1'b0;
        tbl[1].re[5] = 9'h100; tbl[1].im[5] = 9'h100;
        tbl[1].mag_l1[5] = 18'd512; tbl[1].mag_sq[5] = 18'd131072;
        tbl[1].pk_bin = 3'd5; tbl[1].pk_l1 = 18'd512; tbl[1].pk_sq = 18'd131072;
        tbl[1].toggle = 1'b0; tbl[1].mid_start = 1'b0; tbl[1].start_at_done = 1'b1;
        tbl[2].re[2] = 9'd30;  tbl[2].im[2] = 9'h1F6;
        tbl[2].re[6] = 9'h1F6; tbl[2].im[6] = 9'd30;
        tbl[2].mag_l1[2] = 18'd40; tbl[2].mag_sq[2] = 18'd1000;
        tbl[2].mag_l1[6] = 18'd40; tbl[2].mag_sq[6] = 18'd1000;
        tbl[2].pk_bin = 3'd2; tbl[2].pk_l1 = 18'd40; tbl[2].pk_sq = 18'd1000;
        tbl[2].toggle = 1'b0; tbl[2].mid_start = 1'b0; tbl[2].start_at_done = 1'b0;
        tbl[3] = tbl[0];
        tbl[3].toggle = 1'b1; tbl[3].mid_start = 1'b1;

        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel", sel, 0);
        check("rst_outs", {out_bin, out_re, out_im, out_mag}, 0);
        check("rst_peak", {peak_bin, peak_mag}, 0);
        rst_n = 1'b1;

        for (int f = 0; f < 4; f++) run_frame(f);

        // Reset while bin 4 is waiting in OUTPUT.
        begin
            bit hit = 1'b0;
            int dcnt = 0;
            cur = 0;
            @(negedge clk);
            start = 1'b1;
            for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
                @(negedge clk);
                start = 1'b0;
                out_ready = 1'b1;
                if (out_valid && out_bin == 3'd4) begin
                    out_ready = 1'b0;
                    rst_n = 1'b0;
                    hit = 1'b1;
                end
            end
            check("reach_bin4", hit, 1);
            @(negedge clk);
            rst_n = 1'b1;
            out_ready = 1'b1;
            check("abort_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_sel", sel, 0);
            check("abort_peak_mag", peak_mag, 0);
            check("abort_peak_bin", peak_bin, 0);
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(negedge clk);
                if (done) dcnt++;
            end
            check("abort_no_done", dcnt, 0);
            check("abort_stays_idle", busy, 0);
        end
        run_frame(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
